// File: rtl/enc_16_to_4_seq.sv
// Sequential 16-to-4 encoder: captures a request vector and emits the address of each set bit,
// one per handshake, in priority order. DONE pulses once the captured vector is exhausted.
module enc_16_to_4_seq #(
  parameter int unsigned PRIORITY_LOW = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] REQ,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  output logic [3:0]  ADDR,
  output logic        ADDR_VALID,
  input  logic        ADDR_READY,
  output logic        DONE,
  output logic [4:0]  COUNT
);

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 5;

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [IW-1:0]   addr_q, addr_d;
  logic            addr_valid_q, addr_valid_d;
  logic            req_ready_q, req_ready_d;
  logic            done_q, done_d;
  logic [CW-1:0]   count_q, count_d;

  // Index of the highest-priority set bit; the last match in the scan wins.
  function automatic logic [IW-1:0] pick_idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (PRIORITY_LOW != 0) begin
        if (v[N-1-i]) idx = IW'(N-1-i);
      end else begin
        if (v[i]) idx = IW'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Decoder wiring is bit-mirrored: ADDR[0] carries the index MSB.
  function automatic logic [IW-1:0] addr_code(input logic [IW-1:0] idx);
    logic [IW-1:0] code;
    for (int i = 0; i < int'(IW); i++) code[i] = idx[IW-1-i];
    return code;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          pend_d  = REQ;
          count_d = popcount(REQ);
          if (REQ != '0) state_d = S_EMIT;
          else           done_d  = 1'b1;
        end
      end
      S_EMIT: begin
        if (ADDR_READY) begin
          pend_d = pend_q & ~(N'(1) << pick_idx(pend_q));
          if (pend_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are precomputed from next state so they leave the block straight from flops.
    addr_valid_d = (state_d == S_EMIT);
    req_ready_d  = (state_d == S_IDLE);
    addr_d       = addr_valid_d ? addr_code(pick_idx(pend_d)) : addr_q;
  end

  assign REQ_READY  = req_ready_q;
  assign ADDR       = addr_q;
  assign ADDR_VALID = addr_valid_q;
  assign DONE       = done_q;
  assign COUNT      = count_q;

endmodule

// File: doc/enc_16_to_4_seq.md
Name: enc_16_to_4_seq

Overview:
Sequential 16-to-4 encoder, the inverse of the team's 4-to-16 address decoder. It accepts a 16-bit request vector through a valid/ready handshake. It then emits the 4-bit address of every set bit, one per handshake, in priority order, and pulses DONE when the vector is exhausted. Each emitted ADDR, when applied to the 4-to-16 decoder, reproduces a one-hot DEC equal to the bit being serviced.

Parameters:
PRIORITY_LOW, 1, 1 = index 0 is serviced first (ascending order); 0 = index 15 is serviced first (descending order).

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
REQ  input  16  request vector; bit i set = index i pending
REQ_VALID  input  1  REQ is valid this cycle
REQ_READY  output  1  block can capture REQ
ADDR  output  4  encoded address of the bit currently serviced
ADDR_VALID  output  1  ADDR is valid
ADDR_READY  input  1  consumer accepts ADDR
DONE  output  1  one-cycle pulse: captured vector fully serviced
COUNT  output  5  popcount of the last captured vector (0..16)

Behaviour:
- Clocking and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: REQ_READY=0 while RST_N=0, then 1 from the first cycle after release. ADDR=0, ADDR_VALID=0, DONE=0, COUNT=0. The internal pending register is cleared.
- Address code: for index i, ADDR[0]=i[3], ADDR[1]=i[2], ADDR[2]=i[1], ADDR[3]=i[0]. ADDR[0] is the MSB of the index. Examples: i=1 gives 4'b1000, i=8 gives 4'b0001, i=5 gives 4'b1010.
- State machine: IDLE, EMIT.
- IDLE:
  - REQ_READY=1 and ADDR_VALID=0.
  - On REQ_VALID & REQ_READY at edge N: PEND<=REQ and COUNT<=popcount(REQ).
  - If REQ!=0, go to EMIT; ADDR_VALID=1 from cycle N+1, so first-address latency is 1 cycle.
  - If REQ==0, stay in IDLE and pulse DONE in cycle N+1. No ADDR is emitted.
- EMIT:
  - REQ_READY=0; REQ and REQ_VALID are ignored.
  - ADDR = code of the highest-priority set bit of PEND.
  - ADDR and ADDR_VALID are driven from registered state only, with no combinational path from any input.
  - While ADDR_READY=0, ADDR stays stable and ADDR_VALID stays 1.
  - On ADDR_VALID & ADDR_READY at edge M: clear that bit in PEND.
  - If bits remain, the next ADDR appears in cycle M+1. With ADDR_READY held high, throughput is one address per cycle.
  - If no bits remain, go to IDLE. DONE=1 for cycle M+1 only, and REQ_READY=1 in that same cycle.
- Simultaneous events: a REQ_VALID during the DONE cycle is accepted, so back-to-back vectors are serviced with one bubble cycle.
- COUNT is held until the next capture, including a capture of a zero vector.
- Reset mid-operation: any RST_N assertion immediately aborts. PEND is discarded, and every output returns to its reset value. No DONE is generated for the aborted vector.
- PRIORITY_LOW only changes the service order. The code mapping is unaffected.

Test Plan:
- Reset release, then REQ=16'h0001 with REQ_VALID for 1 cycle and ADDR_READY=1 -> next cycle ADDR=4'b0000, ADDR_VALID=1, COUNT=1. The following cycle DONE=1 and REQ_READY=1.
- PRIORITY_LOW=1, REQ=16'h8002 -> ADDR=4'b1000 (i=1), then ADDR=4'b1111 (i=15) on consecutive cycles, then DONE pulse, COUNT=2. Repeat with PRIORITY_LOW=0 -> order is 4'b1111 then 4'b1000.
- Backpressure: REQ=16'h0120 with ADDR_READY=0 for 3 cycles -> ADDR=4'b1010 (i=5) held stable with ADDR_VALID=1 for all 3 cycles. After ADDR_READY rises, the next ADDR is 4'b0001 (i=8). REQ_READY=0 throughout and a REQ_VALID pulse during EMIT is ignored.
- REQ=16'h0000 -> DONE=1 exactly one cycle after acceptance, ADDR_VALID never asserted, COUNT=0.
- REQ=16'hFFFF, ADDR_READY=1 -> 16 addresses on consecutive cycles, each fed to the 4-to-16 decoder yielding DEC=1<<i for i=0..15 in order. Then DONE and COUNT=16. A second vector REQ=16'h0004 presented during the DONE cycle is accepted, and its ADDR=4'b0100 appears the next cycle.
- REQ=16'hFFFF, assert RST_N=0 after 4 addresses -> ADDR_VALID=0 and COUNT=0 immediately, with no DONE pulse. After release, REQ_READY=1 and a new REQ=16'h0008 yields ADDR=4'b1100.
